modinv_helper_invert_update: RTL and testbench

- Executes one binary-inversion update step on the u/v word buffers.
- Consumes the flags produced by the invert-compare stage: u_is_even, v_is_even and u_gt_v.
- Reads both operands word-serially and writes the updated operand back into its own buffer. The other operand is left untouched.
- Sits directly downstream of the compare helper inside the modular invertor loop, under control of the invertor FSM.

---
 rtl/modinv_helper_invert_update_if.sv | 30 +++
 rtl/modinv_helper_invert_update.sv | 188 ++++++++++++++++++
 tb/tb_modinv_helper_invert_update.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modinv_helper_invert_update_if.sv
// Port bundle for the invert-update helper: start/flags, shared read port and the two write ports.
interface modinv_helper_invert_update_if #(
  parameter int unsigned BUFFER_ADDR_BITS = 4
) ();
  logic                        ena;
  logic                        rdy;
  logic                        u_is_even;
  logic                        v_is_even;
  logic                        u_gt_v;
  logic [BUFFER_ADDR_BITS-1:0] rd_addr;
  logic [31:0]                 u_din;
  logic [31:0]                 v_din;
  logic                        u_wr_en;
  logic [BUFFER_ADDR_BITS-1:0] u_wr_addr;
  logic [31:0]                 u_dout;
  logic                        v_wr_en;
  logic [BUFFER_ADDR_BITS-1:0] v_wr_addr;
  logic [31:0]                 v_dout;
  logic [1:0]                  op;

  modport master (
    output ena, u_is_even, v_is_even, u_gt_v, u_din, v_din,
    input  rdy, rd_addr, u_wr_en, u_wr_addr, u_dout, v_wr_en, v_wr_addr, v_dout, op
  );

  modport slave (
    input  ena, u_is_even, v_is_even, u_gt_v, u_din, v_din,
    output rdy, rd_addr, u_wr_en, u_wr_addr, u_dout, v_wr_en, v_wr_addr, v_dout, op
  );
endinterface

// File: rtl/modinv_helper_invert_update.sv
// One binary-inversion update step on the u/v word buffers (halve or subtract, word-serial, in place).
// Optional MODINV_INVERT_FUSED_HALVE_EN: subtract ops write (a-b)>>1 in one pass, one word later.
module modinv_helper_invert_update #(
  parameter int unsigned BUFFER_NUM_WORDS = 9,
  parameter int unsigned BUFFER_ADDR_BITS = 4
) (
  input logic                          clk,
  input logic                          rst,
  modinv_helper_invert_update_if.slave bus
);

  localparam int unsigned AW = BUFFER_ADDR_BITS;
  localparam int unsigned CW = $clog2(BUFFER_NUM_WORDS + 5);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);
  localparam logic [CW-1:0] C_N     = CW'(BUFFER_NUM_WORDS);
  localparam logic [CW-1:0] C_DLAST = CW'(BUFFER_NUM_WORDS + 1);
  localparam logic [CW-1:0] C_END   = CW'(BUFFER_NUM_WORDS + 2);
  localparam logic [AW-1:0] A_MSW   = AW'(BUFFER_NUM_WORDS - 1);
`ifdef MODINV_INVERT_FUSED_HALVE_EN
  localparam logic [CW-1:0] C_THREE = CW'(3);
  localparam logic [CW-1:0] C_END_F = CW'(BUFFER_NUM_WORDS + 3);
`endif

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    op_q, op_nxt;
  logic [AW-1:0] rd_addr_q, rd_addr_nxt;
  logic [AW-1:0] wr_addr_q, wr_addr_nxt;
  logic          cy_q, cy_nxt;
  logic          u_wr_q, u_wr_nxt;
  logic          v_wr_q, v_wr_nxt;
  logic          rdy_q, rdy_nxt;
  logic [31:0]   dout_q, dout_nxt;
`ifdef MODINV_INVERT_FUSED_HALVE_EN
  logic [31:0]   prev_q, prev_nxt;
`endif

  logic [31:0]   a_word, b_word, wr_data;
  logic [32:0]   diff;
  logic          wr_req;
  logic [CW-1:0] wr_idx;
  logic [1:0]    op_sel;

  // Shifts walk MSW->LSW (carry flows down), subtracts walk LSW->MSW (borrow flows up).
  function automatic logic [AW-1:0] word_addr(input logic asc, input logic [CW-1:0] idx);
    return asc ? AW'(idx) : A_MSW - AW'(idx);
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_nxt      = op_q;
    rd_addr_nxt = rd_addr_q;
    cy_nxt      = cy_q;
    u_wr_nxt    = 1'b0;
    v_wr_nxt    = 1'b0;
    wr_addr_nxt = wr_addr_q;
    dout_nxt    = dout_q;
    rdy_nxt     = rdy_q;
    wr_req      = 1'b0;
    wr_idx      = '0;
    wr_data     = '0;
    op_sel      = 2'd3;
`ifdef MODINV_INVERT_FUSED_HALVE_EN
    prev_nxt    = prev_q;
`endif

    // op[0] selects the target buffer: 0 -> u, 1 -> v.
    a_word = op_q[0] ? bus.v_din : bus.u_din;
    b_word = op_q[0] ? bus.u_din : bus.v_din;
    diff   = {1'b0, a_word} - {1'b0, b_word} - {32'b0, cy_q};

    if (bus.u_is_even)      op_sel = 2'd0;
    else if (bus.v_is_even) op_sel = 2'd1;
    else if (bus.u_gt_v)    op_sel = 2'd2;

    case (state)
      ST_IDLE: begin
        if (bus.ena) begin
          state_nxt   = ST_BUSY;
          cnt_nxt     = C_ONE;
          op_nxt      = op_sel;
          rdy_nxt     = 1'b0;
          cy_nxt      = 1'b0;
          rd_addr_nxt = word_addr(op_sel[1], '0);
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt + C_ONE;
        if (cnt < C_N) rd_addr_nxt = word_addr(op_q[1], cnt);
        // Read data for word (cnt-2) is on din this cycle.
        if (cnt >= C_TWO && cnt <= C_DLAST) begin
          if (!op_q[1]) begin
            cy_nxt  = a_word[0];
            wr_req  = 1'b1;
            wr_idx  = cnt - C_TWO;
            wr_data = {cy_q, a_word[31:1]};
          end else begin
            cy_nxt = diff[32];
`ifdef MODINV_INVERT_FUSED_HALVE_EN
            prev_nxt = diff[31:0];
            if (cnt >= C_THREE) begin
              wr_req  = 1'b1;
              wr_idx  = cnt - C_THREE;
              wr_data = {diff[0], prev_q[31:1]};
            end
`else
            wr_req  = 1'b1;
            wr_idx  = cnt - C_TWO;
            wr_data = diff[31:0];
`endif
          end
        end
`ifdef MODINV_INVERT_FUSED_HALVE_EN
        // Flush the halved MSW of the difference.
        if (op_q[1] && cnt == C_END) begin
          wr_req  = 1'b1;
          wr_idx  = C_N - C_ONE;
          wr_data = {1'b0, prev_q[31:1]};
        end
        if (cnt == (op_q[1] ? C_END_F : C_END)) begin
          state_nxt = ST_IDLE;
          rdy_nxt   = 1'b1;
        end
`else
        if (cnt == C_END) begin
          state_nxt = ST_IDLE;
          rdy_nxt   = 1'b1;
        end
`endif
        if (wr_req) begin
          u_wr_nxt    = ~op_q[0];
          v_wr_nxt    = op_q[0];
          wr_addr_nxt = word_addr(op_q[1], wr_idx);
          dout_nxt    = wr_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      cy_q      <= 1'b0;
      u_wr_q    <= 1'b0;
      v_wr_q    <= 1'b0;
      rdy_q     <= 1'b1;
      dout_q    <= '0;
`ifdef MODINV_INVERT_FUSED_HALVE_EN
      prev_q    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_q      <= op_nxt;
      rd_addr_q <= rd_addr_nxt;
      wr_addr_q <= wr_addr_nxt;
      cy_q      <= cy_nxt;
      u_wr_q    <= u_wr_nxt;
      v_wr_q    <= v_wr_nxt;
      rdy_q     <= rdy_nxt;
      dout_q    <= dout_nxt;
`ifdef MODINV_INVERT_FUSED_HALVE_EN
      prev_q    <= prev_nxt;
`endif
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.op        = op_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.u_wr_en   = u_wr_q;
  assign bus.v_wr_en   = v_wr_q;
  assign bus.u_wr_addr = wr_addr_q;
  assign bus.v_wr_addr = wr_addr_q;
  assign bus.u_dout    = dout_q;
  assign bus.v_dout    = dout_q;

endmodule

// File: tb/tb_modinv_helper_invert_update.sv
// Bench for modinv_helper_invert_update: RAM models, write scoreboard, vector table, corner sequences.
module tb_modinv_helper_invert_update;

  localparam int unsigned N = 9;
  localparam int unsigned W = 32 * N;
`ifdef MODINV_INVERT_FUSED_HALVE_EN
  localparam bit FUSED = 1'b1;
`else
  localparam bit FUSED = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic         ue;
    logic         ve;
    logic         gt;
    logic [1:0]   op;
    logic [W-1:0] eu;
    logic [W-1:0] ev;
  } vec_t;

  typedef struct {
    logic        tgt;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  modinv_helper_invert_update_if #(.BUFFER_ADDR_BITS(4)) bus ();

  modinv_helper_invert_update #(
    .BUFFER_NUM_WORDS(N),
    .BUFFER_ADDR_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] u_mem [16];
  logic [31:0] v_mem [16];
  wr_t  sbq [$];
  vec_t vecs [8];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   step_len = 0;
  int   tick_no = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  int   acc_gap = 0;
  logic busy = 1'b0;
  logic [1:0] exp_op = 2'd0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack_u();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = u_mem[i];
    return r;
  endfunction

  function automatic logic [W-1:0] pack_v();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = v_mem[i];
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] u, input logic [W-1:0] v);
    logic [W-1:0] r;
    case (op)
      2'd0:    r = u >> 1;
      2'd1:    r = v >> 1;
      2'd2:    r = FUSED ? (u - v) >> 1 : u - v;
      default: r = FUSED ? (v - u) >> 1 : v - u;
    endcase
    return r;
  endfunction

  // Accepted start: predict every write of this step, in issue order.
  task automatic push_step();
    logic [1:0]   op;
    logic [W-1:0] res;
    int           lat, idx;
    wr_t          e;
    if (bus.u_is_even)      op = 2'd0;
    else if (bus.v_is_even) op = 2'd1;
    else if (bus.u_gt_v)    op = 2'd2;
    else                    op = 2'd3;
    res = model(op, pack_u(), pack_v());
    lat = (op[1] && FUSED) ? 4 : 3;
    for (int k = 0; k < N; k++) begin
      idx    = op[1] ? k : N - 1 - k;
      e.tgt  = op[0];
      e.addr = 4'(idx);
      e.data = res[idx*32 +: 32];
      e.cyc  = k + lat;
      sbq.push_back(e);
    end
    step_len = N + lat;
    busy     = 1'b1;
    exp_op   = op;
    n_acc++;
    acc_gap  = tick_no - last_acc;
    last_acc = tick_no;
  endtask

  // One clock: observe at negedge, update RAM models, present read data after the edge.
  task automatic tick();
    logic [31:0] nu, nv, wd;
    logic [3:0]  wa;
    logic        exp_rdy;
    logic        accept;
    wr_t         e;
    @(negedge clk);
    tick_no++;
    exp_rdy = !busy || (cyc >= step_len);
    check("rdy", W'(bus.rdy), W'(exp_rdy));
    check("op", W'(bus.op), W'(exp_op));
    if (bus.u_wr_en || bus.v_wr_en) begin
      wa = bus.v_wr_en ? bus.v_wr_addr : bus.u_wr_addr;
      wd = bus.v_wr_en ? bus.v_dout : bus.u_dout;
      if (sbq.size() == 0) begin
        check("spurious_wr", W'({bus.v_wr_en, bus.u_wr_en}), '0);
      end else begin
        e = sbq.pop_front();
        check("wr{v,u,addr,data,cyc}",
              W'({bus.v_wr_en, bus.u_wr_en, wa, wd, 8'(cyc)}),
              W'({e.tgt, ~e.tgt, e.addr, e.data, 8'(e.cyc)}));
      end
    end
    nu = u_mem[bus.rd_addr];
    nv = v_mem[bus.rd_addr];
    if (bus.u_wr_en) u_mem[bus.u_wr_addr] = bus.u_dout;
    if (bus.v_wr_en) v_mem[bus.v_wr_addr] = bus.v_dout;
    if (busy && cyc >= step_len) busy = 1'b0;
    accept = 1'b0;
    if (rst) begin
      sbq.delete();
      busy   = 1'b0;
      exp_op = 2'd0;
    end else if (bus.ena && exp_rdy) begin
      push_step();
      accept = 1'b1;
    end
    cyc = accept ? 1 : cyc + 1;
    @(posedge clk);
    #1;
    bus.u_din = nu;
    bus.v_din = nv;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40 && busy; i++) tick();
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: rdy never returned, got busy expected idle", nm);
    end
    check({nm, "_pending_writes"}, W'(sbq.size()), '0);
  endtask

  task automatic load(input logic [W-1:0] u, input logic [W-1:0] v);
    for (int i = 0; i < 16; i++) begin
      u_mem[i] = (i < N) ? u[i*32 +: 32] : 32'h0;
      v_mem[i] = (i < N) ? v[i*32 +: 32] : 32'h0;
    end
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    load(t.u, t.v);
    bus.u_is_even = t.ue;
    bus.v_is_even = t.ve;
    bus.u_gt_v    = t.gt;
    bus.ena       = 1'b1;
    tick();
    bus.ena = 1'b0;
    check({nm, "_op"}, W'(bus.op), W'(t.op));
    wait_idle(nm);
    check({nm, "_u"}, pack_u(), t.eu);
    check({nm, "_v"}, pack_v(), t.ev);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b0; bus.u_is_even = 1'b0; bus.v_is_even = 1'b0; bus.u_gt_v = 1'b0;
    bus.u_din = '0; bus.v_din = '0;
    load('0, '0);

    // {u, v, u_is_even, v_is_even, u_gt_v, op, expected u, expected v}
    vecs[0] = '{W'(64'h3_0000_0000), W'(32'h1234_5679), 1'b1, 1'b0, 1'b0, 2'd0,
                W'(64'h1_8000_0000), W'(32'h1234_5679)};
    vecs[1] = '{W'(1), {{8{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}, 1'b0, 1'b1, 1'b0, 2'd1,
                W'(1), {32'h7FFF_FFFF, {8{32'hFFFF_FFFF}}}};
    vecs[2] = '{W'(64'h1_0000_0001), W'(3), 1'b0, 1'b0, 1'b1, 2'd2,
                FUSED ? W'(32'h7FFF_FFFF) : W'(32'hFFFF_FFFE), W'(3)};
    vecs[3] = '{W'(5), W'(7), 1'b0, 1'b0, 1'b0, 2'd3,
                W'(5), FUSED ? W'(1) : W'(2)};
    vecs[4] = '{W'(8), W'(4), 1'b1, 1'b1, 1'b1, 2'd0, W'(4), W'(4)};
    vecs[5] = '{W'(9), W'(6), 1'b0, 1'b1, 1'b1, 2'd1, W'(9), W'(3)};
    vecs[6] = '{{32'h1, 224'h0, 32'h1}, W'(3), 1'b0, 1'b0, 1'b1, 2'd2,
                FUSED ? {32'h0, 32'h7FFF_FFFF, {7{32'hFFFF_FFFF}}}
                      : {32'h0, {7{32'hFFFF_FFFF}}, 32'hFFFF_FFFE},
                W'(3)};
    vecs[7] = '{W'(3), {32'h1, 224'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 2'd3,
                W'(3),
                FUSED ? {32'h0, 32'h7FFF_FFFF, {7{32'hFFFF_FFFF}}}
                      : {32'h0, {7{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}};

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", W'(bus.rdy), W'(1));
    check("rst_op", W'(bus.op), W'(0));
    check("rst_wr_en", W'({bus.u_wr_en, bus.v_wr_en}), W'(0));
    check("rst_rd_addr", W'(bus.rd_addr), W'(0));
    check("rst_wr_addr", W'({bus.u_wr_addr, bus.v_wr_addr}), W'(0));
    check("rst_dout", W'({bus.u_dout, bus.v_dout}), W'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ena held high: the second step must start in the cycle rdy returns.
    load(W'(32'h10), W'(3));
    bus.u_is_even = 1'b1; bus.v_is_even = 1'b0; bus.u_gt_v = 1'b0;
    n_acc = 0;
    bus.ena = 1'b1;
    for (int i = 0; i < 60 && n_acc < 2; i++) tick();
    bus.ena = 1'b0;
    check("b2b_gap", W'(acc_gap), W'(N + 3));
    wait_idle("b2b");
    check("b2b_u", pack_u(), W'(4));
    check("b2b_v", pack_v(), W'(3));

    // ena pulses and flag changes while busy must be ignored.
    load(W'(5), W'(7));
    bus.u_is_even = 1'b0; bus.v_is_even = 1'b0; bus.u_gt_v = 1'b0;
    bus.ena = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      bus.ena       = i[0];
      bus.u_is_even = 1'($urandom_range(0, 1));
      bus.v_is_even = 1'($urandom_range(0, 1));
      bus.u_gt_v    = 1'($urandom_range(0, 1));
      tick();
    end
    bus.ena = 1'b0;
    wait_idle("busy_ign");
    check("busy_ign_op", W'(bus.op), W'(3));
    check("busy_ign_u", pack_u(), W'(5));
    check("busy_ign_v", pack_v(), FUSED ? W'(1) : W'(2));

    // Reset in cycle 5 of a subtract step aborts it.
    load(vecs[2].u, vecs[2].v);
    bus.u_is_even = 1'b0; bus.v_is_even = 1'b0; bus.u_gt_v = 1'b1;
    bus.ena = 1'b1;
    tick();
    bus.ena = 1'b0;
    while (cyc < 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_wr_en", W'({bus.u_wr_en, bus.v_wr_en}), W'(0));
    check("abort_rdy", W'(bus.rdy), W'(1));
    check("abort_op", W'(bus.op), W'(0));
    tick();
    run_vec(vecs[3], "after_rst");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
